// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM access arbiter.
// Contents:
//   state_t      - sequencer states (IDLE, ACCESS, RDWAIT, RESP)
//   REQ_A/REQ_B  - requester identifiers as carried on rsp_id and in last_grant
//   grant_to_id  - converts a one-hot {B,A} grant vector into a requester id
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // Bit 1 of the grant vector belongs to B, so it is directly the requester id.
    function automatic logic grant_to_id(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin arbiter with its last_grant history register.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   req_a, req_b  qualified requests (already gated by the caller's idle condition)
//   take          a grant was accepted this cycle; updates the history
//   grant         one-hot {B,A} combinational grant
module sram_rr_arbiter
    import sram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       take,
    output logic [1:0] grant
);

    logic last_grant_r;

    // Grant selection: a lone request wins, a tie goes to whoever was not served last.
    always_comb begin
        grant = 2'b00;
        if (req_a && req_b) begin
            if (last_grant_r == REQ_A) begin
                grant = 2'b10;
            end else begin
                grant = 2'b01;
            end
        end else if (req_a) begin
            grant = 2'b01;
        end else if (req_b) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end

    // History register; B counts as last served after reset so A wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_r <= REQ_B;
        end else if (take) begin
            last_grant_r <= grant_to_id(grant);
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Sequences all accesses to the SRAM array on behalf of two requesters (A, B).
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   a_valid/a_ready/a_we/a_addr/a_wdata requester A request channel
//   b_valid/b_ready/b_we/b_addr/b_wdata requester B request channel
//   rsp_valid/rsp_ready/rsp_id/rsp_err/rsp_rdata  single shared response channel
//   dec_addr/dec_en                    word-line decoder drive
//   mem_we/mem_wdata                   array write strobe and data
//   mem_rdata                          registered array read data (valid the cycle after dec_en)
// One request is in flight at a time; ready is only offered in IDLE.
module sram_access_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] dec_addr,
    output logic              dec_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // One extra bit so DEPTH == 2**ADDR_W still fits in the compare.
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    state_t            state_r;
    logic              req_we_r;
    logic              req_id_r;
    logic              idle_s;
    logic              take_s;
    logic [1:0]        grant_s;
    logic              sel_id_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_err_s;

    // Ready is withheld in reset so nothing looks accepted while rst_n is low.
    assign idle_s  = (state_r == IDLE) && rst_n;
    assign a_ready = grant_s[0];
    assign b_ready = grant_s[1];
    // A grant bit is only set for a valid requester, so any grant is a handshake.
    assign take_s  = |grant_s;

    sram_rr_arbiter u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req_a (a_valid && idle_s),
        .req_b (b_valid && idle_s),
        .take  (take_s),
        .grant (grant_s)
    );

    // Steer the granted requester's fields and range-check its address.
    always_comb begin
        sel_id_s    = REQ_A;
        sel_we_s    = a_we;
        sel_addr_s  = a_addr;
        sel_wdata_s = a_wdata;
        if (grant_s[1]) begin
            sel_id_s    = REQ_B;
            sel_we_s    = b_we;
            sel_addr_s  = b_addr;
            sel_wdata_s = b_wdata;
        end else begin
            sel_id_s    = REQ_A;
            sel_we_s    = a_we;
            sel_addr_s  = a_addr;
            sel_wdata_s = a_wdata;
        end
        sel_err_s = ({1'b0, sel_addr_s} >= DEPTH_L);
    end

    // Sequencer: decoder drive and response are loaded one state ahead so every output is a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            req_we_r  <= 1'b0;
            req_id_r  <= REQ_A;
            dec_en    <= 1'b0;
            dec_addr  <= {ADDR_W{1'b0}};
            mem_we    <= 1'b0;
            mem_wdata <= {DATA_W{1'b0}};
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (take_s) begin
                        req_we_r <= sel_we_s;
                        req_id_r <= sel_id_s;
                        if (sel_err_s) begin
                            // Bad address: skip the array entirely and answer next cycle.
                            state_r   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_id    <= sel_id_s;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= {DATA_W{1'b0}};
                        end else begin
                            state_r   <= ACCESS;
                            dec_en    <= 1'b1;
                            dec_addr  <= sel_addr_s;
                            mem_we    <= sel_we_s;
                            mem_wdata <= sel_wdata_s;
                        end
                    end
                end
                ACCESS: begin
                    dec_en    <= 1'b0;
                    dec_addr  <= {ADDR_W{1'b0}};
                    mem_we    <= 1'b0;
                    mem_wdata <= {DATA_W{1'b0}};
                    if (req_we_r) begin
                        state_r   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_id    <= req_id_r;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= {DATA_W{1'b0}};
                    end else begin
                        state_r <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    // Array output is registered, so the word is valid now.
                    state_r   <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_id    <= req_id_r;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= mem_rdata;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r   <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_id    <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= {DATA_W{1'b0}};
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    dec_en    <= 1'b0;
                    dec_addr  <= {ADDR_W{1'b0}};
                    mem_we    <= 1'b0;
                    mem_wdata <= {DATA_W{1'b0}};
                    rsp_valid <= 1'b0;
                    rsp_id    <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= {DATA_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench: main instance (DEPTH=20) checked every cycle against a
// transaction-timeline model; a second instance (DEPTH=32) checks the address boundaries.
module tb_sram_access_arbiter;

    localparam int DEPTH_MAIN = 20;

    logic clk = 1'b0;
    logic rst_n;
    logic a_valid, a_ready, a_we, b_valid, b_ready, b_we;
    logic [4:0] a_addr, b_addr, dec_addr;
    logic [7:0] a_wdata, b_wdata, rsp_rdata, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic rsp_valid, rsp_ready, rsp_id, rsp_err, dec_en, mem_we;

    logic c_valid, c_ready, c_we, c_b_ready, c_rsp_valid, c_rsp_id, c_rsp_err, c_dec_en, c_mem_we;
    logic c_rsp_ready = 1'b1;
    logic [4:0] c_addr, c_dec_addr;
    logic [7:0] c_wdata, c_rsp_rdata, c_mem_wdata;
    logic [7:0] c_mem_rdata = 8'h00;

    logic [7:0] smem [0:31];
    logic [7:0] smem32 [0:31];
    logic [7:0] ref_mem [0:31];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_access_arbiter #(.DATA_W(8), .ADDR_W(5), .DEPTH(DEPTH_MAIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .dec_addr(dec_addr), .dec_en(dec_en), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    sram_access_arbiter #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(c_valid), .a_ready(c_ready), .a_we(c_we), .a_addr(c_addr), .a_wdata(c_wdata),
        .b_valid(1'b0), .b_ready(c_b_ready), .b_we(1'b0), .b_addr(5'd0), .b_wdata(8'd0),
        .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready), .rsp_id(c_rsp_id), .rsp_err(c_rsp_err),
        .rsp_rdata(c_rsp_rdata), .dec_addr(c_dec_addr), .dec_en(c_dec_en), .mem_we(c_mem_we),
        .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata)
    );

    // Array stubs with registered read data.
    always @(posedge clk) begin
        if (dec_en) begin
            if (mem_we) smem[dec_addr] <= mem_wdata;
            mem_rdata <= smem[dec_addr];
        end
        if (c_dec_en) begin
            if (c_mem_we) smem32[c_dec_addr] <= c_mem_wdata;
            c_mem_rdata <= smem32[c_dec_addr];
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transaction accepted in cycle ts has a fixed timeline: dec_en at ts+1 (unless error),
    // response from ts+1 (error), ts+2 (write) or ts+3 (read) until consumed.
    int   cyc = 0;
    bit   armed = 1'b0;
    bit   busy = 1'b0;
    bit   last_b = 1'b1;
    int   ts;
    bit   t_we, t_err, t_id;
    logic [4:0] t_addr;
    logic [7:0] t_wdata, t_rdata;

    always @(negedge clk) begin
        bit e_a, e_b, e_dec, e_rv;
        int d, lat;
        cyc++;
        if (armed) begin
            e_a = 1'b0; e_b = 1'b0; e_dec = 1'b0; e_rv = 1'b0;
            if (!busy && rst_n) begin
                if (a_valid && b_valid) begin
                    e_a = last_b;
                    e_b = !last_b;
                end else begin
                    e_a = a_valid;
                    e_b = b_valid;
                end
            end
            if (busy) begin
                d     = cyc - ts;
                lat   = t_err ? 1 : (t_we ? 2 : 3);
                e_dec = !t_err && (d == 1);
                e_rv  = (d >= lat);
            end
            cmp("a_ready", a_ready, e_a);
            cmp("b_ready", b_ready, e_b);
            cmp("dec_en", dec_en, e_dec);
            cmp("rsp_valid", rsp_valid, e_rv);
            cmp("dec_addr", dec_addr, e_dec ? t_addr : 5'd0);
            cmp("mem_we", mem_we, e_dec ? t_we : 1'b0);
            cmp("mem_wdata", mem_wdata, e_dec ? t_wdata : 8'd0);
            if (e_rv) begin
                cmp("rsp_id", rsp_id, t_id);
                cmp("rsp_err", rsp_err, t_err);
                cmp("rsp_rdata", rsp_rdata, t_rdata);
            end
            if (e_dec && t_we) ref_mem[t_addr] = t_wdata;
            if (!rst_n) begin
                busy   = 1'b0;
                last_b = 1'b1;
            end else if (busy) begin
                if (e_rv && rsp_ready) busy = 1'b0;
            end else if (e_a || e_b) begin
                busy    = 1'b1;
                ts      = cyc;
                t_id    = e_b;
                t_we    = e_b ? b_we : a_we;
                t_addr  = e_b ? b_addr : a_addr;
                t_wdata = e_b ? b_wdata : a_wdata;
                t_err   = (int'(t_addr) >= DEPTH_MAIN);
                t_rdata = (t_err || t_we) ? 8'h00 : ref_mem[t_addr];
                last_b  = e_b;
            end
        end
        if (!rst_n) armed = 1'b1;
    end

    // ---------------- directed helpers ----------------
    task automatic wait_rsp(input bit s32, output logic [7:0] rd, output bit err, output bit id,
                            output int ndec, output logic [4:0] da);
        int n;
        logic v;
        n = 0; v = 1'b0; ndec = 0; da = 5'd0;
        while (!v && n < 50) begin
            @(negedge clk);
            if (s32) begin
                if (c_dec_en) begin ndec++; da = c_dec_addr; end
                v = c_rsp_valid;
            end else begin
                if (dec_en) begin ndec++; da = dec_addr; end
                v = rsp_valid;
            end
            n++;
        end
        cmp("rsp_seen", v, 1'b1);
        if (s32) cmp("c_b_ready_idle", c_b_ready, 1'b0);
        rd  = s32 ? c_rsp_rdata : rsp_rdata;
        err = s32 ? c_rsp_err : rsp_err;
        id  = s32 ? c_rsp_id : rsp_id;
        @(posedge clk); #1;
    endtask

    task automatic req(input bit s32, input bit who, input bit we, input logic [4:0] addr,
                       input logic [7:0] wd, output logic [7:0] rd, output bit err, output bit id,
                       output int ndec, output logic [4:0] da);
        int n;
        logic r;
        if (s32) begin c_valid = 1'b1; c_we = we; c_addr = addr; c_wdata = wd; end
        else if (who) begin b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
        else begin a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
        n = 0; r = 1'b0;
        while (!r && n < 50) begin
            @(negedge clk);
            r = s32 ? c_ready : (who ? b_ready : a_ready);
            n++;
        end
        cmp("req_ready_seen", r, 1'b1);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        wait_rsp(s32, rd, err, id, ndec, da);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rd, rd0;
        bit er, id;
        int nd, n;
        logic [4:0] da;
        bit g [8];

        for (int i = 0; i < 32; i++) begin
            smem[i] = 8'h00; smem32[i] = 8'h00; ref_mem[i] = 8'h00;
        end
        rst_n = 1'b0; rsp_ready = 1'b1;
        a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd7; a_wdata = 8'h5A;
        b_valid = 1'b0; b_we = 1'b0; b_addr = 5'd0; b_wdata = 8'h00;
        c_valid = 1'b0; c_we = 1'b0; c_addr = 5'd0; c_wdata = 8'h00;

        // 1: reset held with a request pending
        repeat (3) begin
            @(negedge clk);
            cmp("rst_a_ready", a_ready, 1'b0);
            cmp("rst_dec_en", dec_en, 1'b0);
            cmp("rst_rsp_valid", rsp_valid, 1'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; b_valid = 1'b1;
        @(negedge clk);
        cmp("first_grant_a", a_ready, 1'b1);
        cmp("first_grant_not_b", b_ready, 1'b0);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;

        // 2: write 0x5A to 7 (accepted above), then read it back
        wait_rsp(1'b0, rd, er, id, nd, da);
        cmp("wr_ndec", nd, 1);
        cmp("wr_dec_addr", da, 5'd7);
        cmp("wr_id", id, 1'b0);
        req(1'b0, 1'b0, 1'b0, 5'd7, 8'h00, rd, er, id, nd, da);
        cmp("rd_ndec", nd, 1);
        cmp("rd_dec_addr", da, 5'd7);
        cmp("rd_data", rd, 8'h5A);
        cmp("rd_id", id, 1'b0);

        // 3: both requesters hammer; grants must alternate, starting with B (A served last)
        a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd3; a_wdata = 8'h11;
        b_valid = 1'b1; b_we = 1'b1; b_addr = 5'd3; b_wdata = 8'h22;
        n = 0;
        for (int k = 0; k < 200 && n < 8; k++) begin
            @(negedge clk);
            if (a_ready || b_ready) begin g[n] = b_ready; n++; end
        end
        cmp("rr_count", n, 8);
        cmp("rr_first_b", g[0], 1'b1);
        for (int i = 1; i < 8; i++) cmp("rr_alternate", g[i], !g[i-1]);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (6) @(posedge clk); #1;

        // 4: read held in RESP with rsp_ready low while both requesters wait
        rsp_ready = 1'b0;
        a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd7;
        n = 0;
        while (!a_ready && n < 50) begin @(negedge clk); n++; end
        cmp("hold_ready_seen", a_ready, 1'b1);
        @(posedge clk); #1;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 5'd1;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        rd0 = rsp_rdata;
        cmp("hold_rdata_val", rd0, 8'h5A);
        repeat (5) begin
            @(negedge clk);
            cmp("hold_rsp_valid", rsp_valid, 1'b1);
            cmp("hold_rdata", rsp_rdata, rd0);
            cmp("hold_a_ready", a_ready, 1'b0);
            cmp("hold_b_ready", b_ready, 1'b0);
            cmp("hold_dec_en", dec_en, 1'b0);
        end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk); #1;

        // 5: range boundaries (DEPTH=20 main, DEPTH=32 second instance)
        req(1'b0, 1'b1, 1'b0, 5'd25, 8'h00, rd, er, id, nd, da);
        cmp("oor_err", er, 1'b1);
        cmp("oor_rdata", rd, 8'h00);
        cmp("oor_id", id, 1'b1);
        cmp("oor_ndec", nd, 0);
        req(1'b0, 1'b0, 1'b1, 5'd20, 8'h77, rd, er, id, nd, da);
        cmp("oor20_err", er, 1'b1);
        req(1'b0, 1'b0, 1'b0, 5'd19, 8'h00, rd, er, id, nd, da);
        cmp("last_word_err", er, 1'b0);
        req(1'b1, 1'b0, 1'b1, 5'd31, 8'h3C, rd, er, id, nd, da);
        cmp("d32_w31_err", er, 1'b0);
        cmp("d32_w31_dec", da, 5'd31);
        req(1'b1, 1'b0, 1'b1, 5'd0, 8'hC3, rd, er, id, nd, da);
        req(1'b1, 1'b0, 1'b0, 5'd31, 8'h00, rd, er, id, nd, da);
        cmp("d32_r31", rd, 8'h3C);
        cmp("d32_r31_err", er, 1'b0);
        req(1'b1, 1'b0, 1'b0, 5'd0, 8'h00, rd, er, id, nd, da);
        cmp("d32_r0", rd, 8'hC3);

        // 6: reset during RDWAIT aborts without a response
        a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd7;
        n = 0;
        while (!a_ready && n < 50) begin @(negedge clk); n++; end
        cmp("abort_ready_seen", a_ready, 1'b1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            cmp("abort_no_rsp", rsp_valid, 1'b0);
        end
        req(1'b0, 1'b0, 1'b0, 5'd7, 8'h00, rd, er, id, nd, da);
        cmp("after_abort_rd", rd, 8'h5A);

        // random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk); #1;
            a_valid   = ($urandom_range(0, 3) != 0);
            a_we      = 1'($urandom_range(0, 1));
            a_addr    = 5'($urandom_range(0, 31));
            a_wdata   = 8'($urandom_range(0, 255));
            b_valid   = ($urandom_range(0, 3) != 0);
            b_we      = 1'($urandom_range(0, 1));
            b_addr    = 5'($urandom_range(0, 31));
            b_wdata   = 8'($urandom_range(0, 255));
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
